pair_dist_gen: RTL and testbench
================================

// Module: pair_dist_gen
// PURPOSE
//  Upstream feeder of the day-8 sort chain. Loads up to NUM_POINTS 3-D points, then streams every unordered
//  pair (i<j) with its squared Euclidean distance as conn_t at 1 pair/clk into the first sort node.
//  After the last pair, pulses sort_read to switch the chain into drain/forward mode.
// PARAMETERS
//  NUM_POINTS  1000  point memory depth; max points per run
//  DIM_W       17    unsigned width of each coordinate
// PORTS
//  clk           in   1        clock
//  rst_n         in   1        async active-low reset
//  start         in   1        pulse; honoured only in IDLE/DONE
//  pt_x/pt_y/pt_z in  DIM_W    point coordinates
//  pt_vld        in   1        point valid
//  pt_last       in   1        qualifies pt_vld; marks final point
//  pt_rdy        out  1        point accepted when pt_vld&&pt_rdy
//  conn_out      out  conn_t   {distance, pointa=i, pointb=j}
//  conn_out_vld  out  1        conn_out valid; no backpressure
//  sort_read     out  1        1-cycle drain pulse to sort chain
//  done          out  1        high in DONE
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; pt_rdy=0, conn_out='0, conn_out_vld=0, sort_read=0, done=0.
//    Pipeline valids and counters cleared. Mid-run reset discards everything; next start is a clean run.
//  - FSM: IDLE -start-> LOAD -> GEN -> FLUSH -> DONE -start-> LOAD.
//  - LOAD: pt_rdy=1. Accepted points written at addr n_pts, then n_pts++.
//    Exit on accepted pt_last or n_pts reaching NUM_POINTS; pt_rdy drops the cycle after the exit.
//    pt_vld in any other state is ignored.
//  - GEN: i=0,j=1 on entry. Each cycle issue (i,j), then j++.
//    If j==n_pts-1: i++, j=i+2. After (n_pts-2, n_pts-1) -> FLUSH. If n_pts<2, skip GEN straight to FLUSH.
//  - Pipeline, issue at t: t+1 operands regd; t+2 |a-b| per dim (DIM_W); t+3 squares (2*DIM_W);
//    t+4 sum (DIST_W=2*DIM_W+2, no overflow) -> conn_out/conn_out_vld regd.
//    Latency 4; back-to-back, no bubbles; exactly n_pts*(n_pts-1)/2 valid beats, order ascending (i,j).
//  - FLUSH: wait until pipeline is empty. Then sort_read=1 for exactly one cycle, the cycle after the last
//    conn_out_vld (or the cycle after LOAD exit if zero pairs). Next cycle enter DONE, done=1.
//  - start in LOAD/GEN/FLUSH ignored. start in DONE clears n_pts/counters, done=0, enters LOAD.
//  - conn_out holds last value when conn_out_vld=0.
// CONFIGURATION
//  PAIR_DIST_GEN_STATS_EN defined: adds output pair_cnt [PAIR_W-1:0].
//    Counts conn_out_vld beats; reset 0; cleared on start; holds in DONE.
//  Undefined: port and counter absent, behaviour otherwise identical.
// STRUCTURE
//  - Package c8_pkg: conn_t {distance[DIST_W], pointa[IDX_W], pointb[IDX_W]}, point_t {x,y,z}.
//    Also IDX_W=$clog2(NUM_POINTS), DIST_W, PAIR_W, and FSM state enum.
//    Shared with sort_node and downstream stages.
//  - Sub-module sq_dist_pipe: 3-stage diff/square/sum with valid + index sideband.
//    Top holds FSM, point memory (2 read ports), pair counters.
// TESTING
//  1. Pts (0,0,0),(1,2,2),(3,0,4), pt_last on 3rd:
//     conns (0,1,9),(0,2,25),(1,2,12) on consecutive cycles; sort_read next cycle; then done=1.
//  2. Pts (0,0,0),(131071,131071,131071), last: single conn distance=51538821123, no truncation.
//  3. Single pt with pt_last: zero conn_out_vld; sort_read 1 cycle after LOAD exit; done=1.
//  4. NUM_POINTS=4, 4 pts no pt_last: pt_rdy low after 4th.
//     6 beats (0,1)(0,2)(0,3)(1,2)(1,3)(2,3); first beat 4 cycles after GEN entry.
//  5. rst_n low mid-GEN: outputs zero immediately (async). Restart with scenario 1 data: identical output.
//  6. STATS_EN on, scenario 4: pair_cnt=6 in DONE; start -> pair_cnt=0.

Source files
------------

// File: rtl/c8_pkg.sv
// Shared types for the day-8 pair/sort chain: point and connection records, widths, FSM states.
package c8_pkg;

    localparam int C8_NUM_POINTS = 1000;
    localparam int COORD_W       = 17;
    localparam int IDX_W         = $clog2(C8_NUM_POINTS);
    localparam int DIST_W        = 2*COORD_W + 2;
    localparam int PAIR_W        = $clog2(C8_NUM_POINTS*(C8_NUM_POINTS-1)/2 + 1);

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] z;
    } point_t;

    typedef struct packed {
        logic [DIST_W-1:0] distance;
        logic [IDX_W-1:0]  pointa;
        logic [IDX_W-1:0]  pointb;
    } conn_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_GEN,
        ST_FLUSH,
        ST_DONE
    } state_t;

    function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                    input logic [COORD_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/pair_dist_gen_sq_dist_pipe.sv
// Three-stage squared-distance pipeline (|diff| -> square -> sum) carrying a valid bit and the pair indices.
module sq_dist_pipe
    import c8_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    input  point_t           a,
    input  point_t           b,
    input  logic [IDX_W-1:0] ia,
    input  logic [IDX_W-1:0] ib,
    output logic             out_vld,
    output conn_t            out_conn,
    output logic             busy
);

    logic [COORD_W-1:0]   dx, dy, dz;
    logic [2*COORD_W-1:0] sx, sy, sz;
    logic                 d_vld, s_vld;
    logic [IDX_W-1:0]     d_ia, d_ib, s_ia, s_ib;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_vld <= 1'b0;
            dx    <= '0;
            dy    <= '0;
            dz    <= '0;
            d_ia  <= '0;
            d_ib  <= '0;
        end else begin
            d_vld <= in_vld;
            dx    <= abs_diff(a.x, b.x);
            dy    <= abs_diff(a.y, b.y);
            dz    <= abs_diff(a.z, b.z);
            d_ia  <= ia;
            d_ib  <= ib;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_vld <= 1'b0;
            sx    <= '0;
            sy    <= '0;
            sz    <= '0;
            s_ia  <= '0;
            s_ib  <= '0;
        end else begin
            s_vld <= d_vld;
            sx    <= {{COORD_W{1'b0}}, dx} * {{COORD_W{1'b0}}, dx};
            sy    <= {{COORD_W{1'b0}}, dy} * {{COORD_W{1'b0}}, dy};
            sz    <= {{COORD_W{1'b0}}, dz} * {{COORD_W{1'b0}}, dz};
            s_ia  <= d_ia;
            s_ib  <= d_ib;
        end
    end

    // Output register only loads on a valid beat so conn holds between beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            out_conn <= '0;
        end else begin
            out_vld <= s_vld;
            if (s_vld) begin
                out_conn.distance <= {2'b00, sx} + {2'b00, sy} + {2'b00, sz};
                out_conn.pointa   <= s_ia;
                out_conn.pointb   <= s_ib;
            end
        end
    end

    assign busy = d_vld || s_vld || out_vld;

endmodule

// File: rtl/pair_dist_gen.sv
// Loads 3-D points, streams every (i<j) pair with squared distance, then pulses sort_read.
// Optional pair_cnt beat counter enabled by defining PAIR_DIST_GEN_STATS_EN.
module pair_dist_gen
    import c8_pkg::*;
#(
    parameter int NUM_POINTS = C8_NUM_POINTS,
    parameter int DIM_W      = COORD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DIM_W-1:0] pt_x,
    input  logic [DIM_W-1:0] pt_y,
    input  logic [DIM_W-1:0] pt_z,
    input  logic             pt_vld,
    input  logic             pt_last,
    output logic             pt_rdy,
    output conn_t            conn_out,
    output logic             conn_out_vld,
    output logic             sort_read,
    output logic             done
`ifdef PAIR_DIST_GEN_STATS_EN
    ,
    output logic [PAIR_W-1:0] pair_cnt
`endif
);

    localparam int CNT_W = $clog2(NUM_POINTS + 1);
    localparam int AW    = (NUM_POINTS > 1) ? $clog2(NUM_POINTS) : 1;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] n_pts, i_idx, j_idx;
    point_t           mem [NUM_POINTS];
    point_t           op_a, op_b;
    logic [IDX_W-1:0] op_ia, op_ib;
    logic             op_vld, pipe_busy;
    logic             start_ok, pt_acc, load_exit, gen_last, pipe_idle;

    assign start_ok  = start && (state == ST_IDLE || state == ST_DONE);
    assign pt_acc    = pt_vld && (state == ST_LOAD);
    assign load_exit = pt_acc && (pt_last || n_pts == CNT_W'(NUM_POINTS - 1));
    assign gen_last  = (i_idx == n_pts - CNT_W'(2)) && (j_idx == n_pts - CNT_W'(1));
    assign pipe_idle = !op_vld && !pipe_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pt_rdy    = 1'b0;
        sort_read = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_LOAD;
            ST_LOAD: begin
                pt_rdy = 1'b1;
                // A lone point yields no pairs, so GEN is skipped.
                if (load_exit) state_nxt = (n_pts == '0) ? ST_FLUSH : ST_GEN;
            end
            ST_GEN:   if (gen_last) state_nxt = ST_FLUSH;
            ST_FLUSH: if (pipe_idle) begin
                sort_read = 1'b1;
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) state_nxt = ST_LOAD;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Pair walker: j runs to the last point, then i advances and j restarts at i+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_pts <= '0;
            i_idx <= '0;
            j_idx <= CNT_W'(1);
        end else begin
            if (start_ok)    n_pts <= '0;
            else if (pt_acc) n_pts <= n_pts + CNT_W'(1);
            if (state != ST_GEN) begin
                i_idx <= '0;
                j_idx <= CNT_W'(1);
            end else if (j_idx == n_pts - CNT_W'(1)) begin
                i_idx <= i_idx + CNT_W'(1);
                j_idx <= i_idx + CNT_W'(2);
            end else begin
                j_idx <= j_idx + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pt_acc) mem[n_pts[AW-1:0]] <= '{x: pt_x, y: pt_y, z: pt_z};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_vld <= 1'b0;
            op_a   <= '0;
            op_b   <= '0;
            op_ia  <= '0;
            op_ib  <= '0;
        end else begin
            op_vld <= (state == ST_GEN);
            if (state == ST_GEN) begin
                op_a  <= mem[i_idx[AW-1:0]];
                op_b  <= mem[j_idx[AW-1:0]];
                op_ia <= IDX_W'(i_idx);
                op_ib <= IDX_W'(j_idx);
            end
        end
    end

    sq_dist_pipe u_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (op_vld),
        .a        (op_a),
        .b        (op_b),
        .ia       (op_ia),
        .ib       (op_ib),
        .out_vld  (conn_out_vld),
        .out_conn (conn_out),
        .busy     (pipe_busy)
    );

`ifdef PAIR_DIST_GEN_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            pair_cnt <= '0;
        else if (start_ok)     pair_cnt <= '0;
        else if (conn_out_vld) pair_cnt <= pair_cnt + PAIR_W'(1);
    end
`endif

endmodule

// File: tb/tb_pair_dist_gen.sv
// Directed self-checking bench for pair_dist_gen (built with NUM_POINTS=4).
module tb_pair_dist_gen;
    import c8_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [COORD_W-1:0] pt_x = '0, pt_y = '0, pt_z = '0;
    logic               pt_vld = 1'b0, pt_last = 1'b0;
    logic               pt_rdy, conn_out_vld, sort_read, done;
    conn_t              conn_out;
`ifdef PAIR_DIST_GEN_STATS_EN
    logic [PAIR_W-1:0]  pair_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int sr_cnt = 0;
    int sr_cyc = -1;
    conn_t beat_q[$];
    int    beat_cyc[$];
    int    px[4], py[4], pz[4];

    always #5 clk = ~clk;

    pair_dist_gen #(.NUM_POINTS(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .pt_x         (pt_x),
        .pt_y         (pt_y),
        .pt_z         (pt_z),
        .pt_vld       (pt_vld),
        .pt_last      (pt_last),
        .pt_rdy       (pt_rdy),
        .conn_out     (conn_out),
        .conn_out_vld (conn_out_vld),
        .sort_read    (sort_read),
        .done         (done)
`ifdef PAIR_DIST_GEN_STATS_EN
        ,
        .pair_cnt     (pair_cnt)
`endif
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (conn_out_vld) begin
            beat_q.push_back(conn_out);
            beat_cyc.push_back(cyc);
        end
        if (sort_read) begin
            sr_cnt = sr_cnt + 1;
            sr_cyc = cyc;
        end
    end

    task automatic start_and_load(input int n, input logic use_last, output int g,
                                  output logic rdy_load, output logic rdy_after);
        beat_q.delete();
        beat_cyc.delete();
        sr_cnt = 0;
        sr_cyc = -1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        rdy_load = pt_rdy;
        for (int k = 0; k < n; k++) begin
            pt_x    = COORD_W'(px[k]);
            pt_y    = COORD_W'(py[k]);
            pt_z    = COORD_W'(pz[k]);
            pt_vld  = 1'b1;
            pt_last = use_last && (k == n - 1);
            @(posedge clk); #1;
        end
        pt_vld    = 1'b0;
        pt_last   = 1'b0;
        g         = cyc;
        rdy_after = pt_rdy;
    endtask

    task automatic wait_done(output int d, output logic to);
        to = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if (done) begin
                to = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        d = cyc;
    endtask

    task automatic test_reset();
        checks += 5;
        if (pt_rdy !== 1'b0)       begin errors++; $display("[TB] FAIL reset_pt_rdy: got %b expected 0", pt_rdy); end
        if (conn_out !== '0)       begin errors++; $display("[TB] FAIL reset_conn_out: got %h expected 0", conn_out); end
        if (conn_out_vld !== 1'b0) begin errors++; $display("[TB] FAIL reset_conn_vld: got %b expected 0", conn_out_vld); end
        if (sort_read !== 1'b0)    begin errors++; $display("[TB] FAIL reset_sort_read: got %b expected 0", sort_read); end
        if (done !== 1'b0)         begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_three_points();
        int g, d;
        logic to, r1, r2;
        longint exp_d[3] = '{9, 25, 12};
        int exp_a[3] = '{0, 0, 1};
        int exp_b[3] = '{1, 2, 2};
        conn_t exp;
        px = '{0, 1, 3, 0}; py = '{0, 2, 0, 0}; pz = '{0, 2, 4, 0};
        start_and_load(3, 1'b1, g, r1, r2);
        wait_done(d, to);
        checks += 6;
        if (to)                  begin errors++; $display("[TB] FAIL three_timeout: done never rose"); end
        if (r1 !== 1'b1)         begin errors++; $display("[TB] FAIL three_pt_rdy: got %b expected 1", r1); end
        if (beat_q.size() != 3)  begin errors++; $display("[TB] FAIL three_beats: got %0d expected 3", beat_q.size()); end
        if (sr_cnt != 1 || sr_cyc != g + 7) begin errors++; $display("[TB] FAIL three_sort_read: got count %0d at %0d expected 1 at %0d", sr_cnt, sr_cyc, g + 7); end
        if (d != g + 8)          begin errors++; $display("[TB] FAIL three_done_cycle: got %0d expected %0d", d, g + 8); end
        for (int k = 0; k < 3 && k < beat_q.size(); k++) begin
            exp = '{distance: DIST_W'(exp_d[k]), pointa: IDX_W'(exp_a[k]), pointb: IDX_W'(exp_b[k])};
            checks += 2;
            if (beat_q[k] !== exp)     begin errors++; $display("[TB] FAIL three_conn%0d: got %0d/%0d/%0d expected %0d/%0d/%0d", k, beat_q[k].distance, beat_q[k].pointa, beat_q[k].pointb, exp_d[k], exp_a[k], exp_b[k]); end
            if (beat_cyc[k] != g + 4 + k) begin errors++; $display("[TB] FAIL three_time%0d: got %0d expected %0d", k, beat_cyc[k], g + 4 + k); end
        end
        exp = '{distance: DIST_W'(12), pointa: IDX_W'(1), pointb: IDX_W'(2)};
        if (conn_out !== exp) begin errors++; $display("[TB] FAIL three_hold: got %h expected %h", conn_out, exp); end
    endtask

    task automatic test_max_coords();
        int g, d;
        logic to, r1, r2;
        conn_t exp;
        px = '{0, 131071, 0, 0}; py = '{0, 131071, 0, 0}; pz = '{0, 131071, 0, 0};
        exp = '{distance: 36'd51538821123, pointa: IDX_W'(0), pointb: IDX_W'(1)};
        start_and_load(2, 1'b1, g, r1, r2);
        wait_done(d, to);
        checks += 4;
        if (to)                 begin errors++; $display("[TB] FAIL max_timeout: done never rose"); end
        if (beat_q.size() != 1) begin errors++; $display("[TB] FAIL max_beats: got %0d expected 1", beat_q.size()); end
        else if (beat_q[0] !== exp || beat_cyc[0] != g + 4) begin errors++; $display("[TB] FAIL max_conn: got %0d at %0d expected %0d at %0d", beat_q[0].distance, beat_cyc[0], exp.distance, g + 4); end
        if (sr_cyc != g + 5 || d != g + 6) begin errors++; $display("[TB] FAIL max_end: got sort_read %0d done %0d expected %0d %0d", sr_cyc, d, g + 5, g + 6); end
    endtask

    task automatic test_single_point();
        int g, d;
        logic to, r1, r2;
        px = '{5, 0, 0, 0}; py = '{6, 0, 0, 0}; pz = '{7, 0, 0, 0};
        start_and_load(1, 1'b1, g, r1, r2);
        wait_done(d, to);
        checks += 4;
        if (to)                 begin errors++; $display("[TB] FAIL single_timeout: done never rose"); end
        if (beat_q.size() != 0) begin errors++; $display("[TB] FAIL single_beats: got %0d expected 0", beat_q.size()); end
        if (sr_cnt != 1 || sr_cyc != g) begin errors++; $display("[TB] FAIL single_sort_read: got count %0d at %0d expected 1 at %0d", sr_cnt, sr_cyc, g); end
        if (d != g + 1)         begin errors++; $display("[TB] FAIL single_done: got %0d expected %0d", d, g + 1); end
    endtask

    task automatic test_full_memory();
        int g, d;
        logic to, r1, r2;
        longint exp_d[6] = '{1, 9, 25, 10, 26, 34};
        int exp_a[6] = '{0, 0, 0, 1, 1, 2};
        int exp_b[6] = '{1, 2, 3, 2, 3, 3};
        conn_t exp;
        px = '{0, 1, 0, 0}; py = '{0, 0, 3, 0}; pz = '{0, 0, 0, 5};
        start_and_load(4, 1'b0, g, r1, r2);
        wait_done(d, to);
        checks += 5;
        if (to)                 begin errors++; $display("[TB] FAIL full_timeout: done never rose"); end
        if (r2 !== 1'b0)        begin errors++; $display("[TB] FAIL full_pt_rdy_drop: got %b expected 0", r2); end
        if (beat_q.size() != 6) begin errors++; $display("[TB] FAIL full_beats: got %0d expected 6", beat_q.size()); end
        if (sr_cnt != 1 || sr_cyc != g + 10) begin errors++; $display("[TB] FAIL full_sort_read: got count %0d at %0d expected 1 at %0d", sr_cnt, sr_cyc, g + 10); end
        if (d != g + 11)        begin errors++; $display("[TB] FAIL full_done: got %0d expected %0d", d, g + 11); end
        for (int k = 0; k < 6 && k < beat_q.size(); k++) begin
            exp = '{distance: DIST_W'(exp_d[k]), pointa: IDX_W'(exp_a[k]), pointb: IDX_W'(exp_b[k])};
            checks += 2;
            if (beat_q[k] !== exp) begin errors++; $display("[TB] FAIL full_conn%0d: got %0d/%0d/%0d expected %0d/%0d/%0d", k, beat_q[k].distance, beat_q[k].pointa, beat_q[k].pointb, exp_d[k], exp_a[k], exp_b[k]); end
            if (beat_cyc[k] != g + 4 + k) begin errors++; $display("[TB] FAIL full_time%0d: got %0d expected %0d", k, beat_cyc[k], g + 4 + k); end
        end
    endtask

`ifdef PAIR_DIST_GEN_STATS_EN
    task automatic test_stats();
        int g, d;
        logic to, r1, r2;
        px = '{0, 1, 0, 0}; py = '{0, 0, 3, 0}; pz = '{0, 0, 0, 5};
        start_and_load(4, 1'b0, g, r1, r2);
        wait_done(d, to);
        checks += 2;
        if (to)                    begin errors++; $display("[TB] FAIL stats_timeout: done never rose"); end
        if (pair_cnt !== PAIR_W'(6)) begin errors++; $display("[TB] FAIL stats_count: got %0d expected 6", pair_cnt); end
        start_and_load(1, 1'b1, g, r1, r2);
        checks += 1;
        if (pair_cnt !== '0)       begin errors++; $display("[TB] FAIL stats_clear: got %0d expected 0", pair_cnt); end
        wait_done(d, to);
    endtask
`endif

    task automatic test_reset_mid_gen();
        int g;
        logic r1, r2;
        px = '{0, 1, 0, 0}; py = '{0, 0, 3, 0}; pz = '{0, 0, 0, 5};
        start_and_load(4, 1'b0, g, r1, r2);
        repeat (4) @(posedge clk);
        #3;
        checks += 1;
        if (conn_out_vld !== 1'b1) begin errors++; $display("[TB] FAIL midrst_pre_vld: got %b expected 1", conn_out_vld); end
        rst_n = 1'b0;
        #1;
        checks += 5;
        if (conn_out_vld !== 1'b0) begin errors++; $display("[TB] FAIL midrst_vld: got %b expected 0", conn_out_vld); end
        if (conn_out !== '0)       begin errors++; $display("[TB] FAIL midrst_conn: got %h expected 0", conn_out); end
        if (pt_rdy !== 1'b0)       begin errors++; $display("[TB] FAIL midrst_pt_rdy: got %b expected 0", pt_rdy); end
        if (sort_read !== 1'b0)    begin errors++; $display("[TB] FAIL midrst_sort_read: got %b expected 0", sort_read); end
        if (done !== 1'b0)         begin errors++; $display("[TB] FAIL midrst_done: got %b expected 0", done); end
        @(posedge clk); #1 rst_n = 1'b1;
        test_three_points();
    endtask

    initial begin
        #2;
        test_reset();
        test_three_points();
        test_max_coords();
        test_single_point();
        test_full_memory();
`ifdef PAIR_DIST_GEN_STATS_EN
        test_stats();
`endif
        test_reset_mid_gen();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
